// File: rtl/load_store_unit.sv
// Load/store unit between execute and a word-only data memory: sub-word extraction,
// read-modify-write for narrow stores, and splitting of word-crossing accesses.
module load_store_unit #(
   parameter int unsigned ADDR_W         = 8,
   parameter bit          ALLOW_MISALIGN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_add,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam int unsigned IDX_W = ADDR_W - 2;

   typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, RESP} state_t;

   function automatic logic [2:0] size_of(input logic [2:0] f3);
      case (f3[1:0])
         2'd0:    return 3'd1;
         2'd1:    return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   function automatic logic crosses(input logic [1:0] off, input logic [2:0] n);
      return (3'(off) + n) > 3'd4;
   endfunction

   // Replace n bytes starting at byte off of the two-word window {word1, word0}.
   function automatic logic [63:0] merge(input logic [63:0] w, input logic [1:0] off,
                                         input logic [2:0] n, input logic [31:0] wd);
      logic [63:0] r;
      r = w;
      for (int i = 0; i < 4; i++)
         if (3'(i) < n) r[(int'(off) + i) * 8 +: 8] = wd[i * 8 +: 8];
      return r;
   endfunction

   function automatic logic [31:0] extract(input logic [63:0] w, input logic [1:0] off,
                                           input logic [2:0] f3);
      logic [63:0] s;
      s = w >> {off, 3'b000};
      case (f3)
         3'd0:    return {{24{s[7]}}, s[7:0]};
         3'd1:    return {{16{s[15]}}, s[15:0]};
         3'd2:    return s[31:0];
         3'd4:    return {24'd0, s[7:0]};
         3'd5:    return {16'd0, s[15:0]};
         default: return 32'd0;
      endcase
   endfunction

   state_t            state;
   logic              we_q;
   logic [2:0]        f3_q;
   logic [1:0]        off_q;
   logic [IDX_W-1:0]  w0_q;
   logic [31:0]       wdata_q;
   logic [31:0]       word0;
   logic [31:0]       word1;

   logic [IDX_W-1:0]  req_idx;
   logic [IDX_W-1:0]  w1;
   logic [2:0]        req_n;
   logic [2:0]        nb_q;
   logic              req_legal;
   logic              req_error;
   logic              req_full_sw;
   logic              cross_q;
   logic [63:0]       merged_rd0;
   logic [63:0]       merged_rd1;
   logic [63:0]       merged_buf;

   // Request decode and store-merge candidates for each possible write entry point.
   always_comb begin
      req_idx     = req_addr[ADDR_W-1:2];
      req_n       = size_of(req_funct3);
      req_legal   = req_we ? (req_funct3 <= 3'd2)
                           : (req_funct3 <= 3'd2 || req_funct3 == 3'd4 || req_funct3 == 3'd5);
      req_error   = !req_legal || (crosses(req_addr[1:0], req_n) && !ALLOW_MISALIGN);
      req_full_sw = req_we && (req_funct3[1:0] == 2'd2) && (req_addr[1:0] == 2'd0);
      w1          = w0_q + IDX_W'(1);
      nb_q        = size_of(f3_q);
      cross_q     = crosses(off_q, nb_q);
      merged_rd0  = merge({32'd0, mem_rdata}, off_q, nb_q, wdata_q);
      merged_rd1  = merge({mem_rdata, word0}, off_q, nb_q, wdata_q);
      merged_buf  = merge({word1, word0}, off_q, nb_q, wdata_q);
   end

   // Sequencer; every output is loaded on the edge that enters the state using it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         mem_add    <= '0;
         mem_wdata  <= '0;
         we_q       <= 1'b0;
         f3_q       <= '0;
         off_q      <= '0;
         w0_q       <= '0;
         wdata_q    <= '0;
         word0      <= '0;
         word1      <= '0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               we_q      <= req_we;
               f3_q      <= req_funct3;
               off_q     <= req_addr[1:0];
               w0_q      <= req_idx;
               wdata_q   <= req_wdata;
               req_ready <= 1'b0;
               if (req_error) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_rdata <= '0;
               end else if (req_full_sw) begin
                  state     <= WR0;
                  mem_write <= 1'b1;
                  mem_add   <= {req_idx, 2'b00};
                  mem_wdata <= req_wdata;
               end else begin
                  state    <= RD0;
                  mem_read <= 1'b1;
                  mem_add  <= {req_idx, 2'b00};
               end
            end
            RD0: begin
               word0 <= mem_rdata;
               if (cross_q) begin
                  state   <= RD1;
                  mem_add <= {w1, 2'b00};
               end else if (we_q) begin
                  state     <= WR0;
                  mem_read  <= 1'b0;
                  mem_write <= 1'b1;
                  mem_wdata <= merged_rd0[31:0];
               end else begin
                  state      <= RESP;
                  mem_read   <= 1'b0;
                  mem_add    <= '0;
                  resp_valid <= 1'b1;
                  resp_rdata <= extract({32'd0, mem_rdata}, off_q, f3_q);
               end
            end
            RD1: begin
               word1    <= mem_rdata;
               mem_read <= 1'b0;
               if (we_q) begin
                  state     <= WR0;
                  mem_write <= 1'b1;
                  mem_add   <= {w0_q, 2'b00};
                  mem_wdata <= merged_rd1[31:0];
               end else begin
                  state      <= RESP;
                  mem_add    <= '0;
                  resp_valid <= 1'b1;
                  resp_rdata <= extract({mem_rdata, word0}, off_q, f3_q);
               end
            end
            WR0: begin
               if (cross_q) begin
                  state     <= WR1;
                  mem_add   <= {w1, 2'b00};
                  mem_wdata <= merged_buf[63:32];
               end else begin
                  state      <= RESP;
                  mem_write  <= 1'b0;
                  mem_add    <= '0;
                  mem_wdata  <= '0;
                  resp_valid <= 1'b1;
                  resp_rdata <= '0;
               end
            end
            WR1: begin
               state      <= RESP;
               mem_write  <= 1'b0;
               mem_add    <= '0;
               mem_wdata  <= '0;
               resp_valid <= 1'b1;
               resp_rdata <= '0;
            end
            RESP: if (resp_ready) begin
               state      <= IDLE;
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               resp_rdata <= '0;
               req_ready  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized and directed bench for load_store_unit against a byte-addressed memory model;
// a second instance covers the no-misalignment configuration.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
   logic [2:0]  req_funct3;
   logic [7:0]  req_addr, mem_add;
   logic [31:0] req_wdata, resp_rdata, mem_wdata, mem_rdata;
   logic        mem_read, mem_write;

   logic        n_req_valid, n_req_ready, n_req_we, n_resp_valid, n_resp_ready, n_resp_err;
   logic [2:0]  n_req_funct3;
   logic [7:0]  n_req_addr, n_mem_add;
   logic [31:0] n_req_wdata, n_resp_rdata, n_mem_wdata, n_mem_rdata;
   logic        n_mem_read, n_mem_write;

   logic [31:0] mem [64];
   logic [31:0] ref_mem [64];
   logic        pl_en;
   logic [5:0]  pl_idx;
   logic [31:0] pl_val;

   int tests = 0;
   int fails = 0;
   int rd_total = 0, wr_total = 0, viol = 0;
   int n_rd_total = 0, n_wr_total = 0;

   always #5 clk = ~clk;

   load_store_unit #(.ADDR_W(8), .ALLOW_MISALIGN(1'b1)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .mem_read(mem_read), .mem_write(mem_write), .mem_add(mem_add),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

   load_store_unit #(.ADDR_W(8), .ALLOW_MISALIGN(1'b0)) dut_nm (
      .clk(clk), .rst(rst), .req_valid(n_req_valid), .req_ready(n_req_ready), .req_we(n_req_we),
      .req_funct3(n_req_funct3), .req_addr(n_req_addr), .req_wdata(n_req_wdata),
      .resp_valid(n_resp_valid), .resp_ready(n_resp_ready), .resp_rdata(n_resp_rdata),
      .resp_err(n_resp_err), .mem_read(n_mem_read), .mem_write(n_mem_write), .mem_add(n_mem_add),
      .mem_wdata(n_mem_wdata), .mem_rdata(n_mem_rdata));

   assign mem_rdata   = mem[mem_add[7:2]];
   assign n_mem_rdata = mem[n_mem_add[7:2]];

   always @(posedge clk) begin
      if (mem_write) mem[mem_add[7:2]] <= mem_wdata;
      else if (pl_en) mem[pl_idx] <= pl_val;
   end

   // Bus activity counters and protocol watch, sampled mid-cycle.
   always @(negedge clk) begin
      if (mem_read) rd_total++;
      if (mem_write) wr_total++;
      if (n_mem_read) n_rd_total++;
      if (n_mem_write) n_wr_total++;
      if ((mem_read && mem_write) || mem_add[1:0] != 2'b00 || (!mem_write && mem_wdata != 0))
         viol++;
   end

   task automatic set_word(input int idx, input logic [31:0] val);
      pl_en = 1'b1; pl_idx = 6'(idx); pl_val = val;
      @(posedge clk); #1;
      pl_en = 1'b0;
      ref_mem[idx] = val;
   endtask

   function automatic logic [7:0] ref_byte(input logic [7:0] a);
      logic [31:0] w;
      w = ref_mem[a[7:2]];
      return w[int'(a[1:0]) * 8 +: 8];
   endfunction

   // One transaction on the main instance, checked against the byte-level model.
   task automatic do_txn(input logic we, input logic [2:0] f3, input logic [7:0] addr,
                         input logic [31:0] wd, input int hold, output logic [31:0] got);
      int sz, lat, n, rd0, wr0, v0, exp_lat, exp_rds, exp_wrs, bad;
      logic legal, cr, exp_err;
      logic [31:0] exp_rd, w;
      logic [7:0] a;
      sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
      legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      cr = (int'(addr[1:0]) + sz) > 4;
      exp_err = !legal;
      exp_rd = 32'd0;
      if (!exp_err && !we) begin
         for (int i = 0; i < sz; i++) begin
            a = addr + 8'(i);
            exp_rd = exp_rd | (32'(ref_byte(a)) << (8 * i));
         end
         if (f3 == 3'd0) exp_rd = {{24{exp_rd[7]}}, exp_rd[7:0]};
         if (f3 == 3'd1) exp_rd = {{16{exp_rd[15]}}, exp_rd[15:0]};
      end
      if (exp_err) begin exp_lat = 1; exp_rds = 0; exp_wrs = 0; end
      else if (we && sz == 4 && addr[1:0] == 2'b00) begin exp_lat = 2; exp_rds = 0; exp_wrs = 1; end
      else if (!we) begin exp_lat = 2 + int'(cr); exp_rds = 1 + int'(cr); exp_wrs = 0; end
      else begin exp_lat = 3 + 2 * int'(cr); exp_rds = 1 + int'(cr); exp_wrs = 1 + int'(cr); end

      n = 0;
      while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
      tests++;
      if (!req_ready) begin fails++; $display("FAIL req_ready_timeout got=%b want=1", req_ready); end
      rd0 = rd_total; wr0 = wr_total; v0 = viol;
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      got = resp_rdata;
      tests++;
      if (lat !== exp_lat) begin
         fails++; $display("FAIL latency we=%b f3=%0d addr=%h got=%0d want=%0d", we, f3, addr, lat, exp_lat);
      end
      tests++;
      if (resp_rdata !== exp_rd || resp_err !== exp_err) begin
         fails++; $display("FAIL resp we=%b f3=%0d addr=%h got=%h/%b want=%h/%b",
                           we, f3, addr, resp_rdata, resp_err, exp_rd, exp_err);
      end
      tests++;
      if (req_ready !== 1'b0) begin fails++; $display("FAIL ready_in_resp got=%b want=0", req_ready); end
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         tests++;
         if (resp_valid !== 1'b1 || resp_rdata !== exp_rd || resp_err !== exp_err) begin
            fails++; $display("FAIL resp_hold cycle=%0d got=%b/%h/%b want=1/%h/%b",
                              i, resp_valid, resp_rdata, resp_err, exp_rd, exp_err);
         end
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      tests++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         fails++; $display("FAIL resp_release got=%b/%b want=0/1", resp_valid, req_ready);
      end
      if (!exp_err && we)
         for (int i = 0; i < sz; i++) begin
            a = addr + 8'(i);
            w = ref_mem[a[7:2]];
            w[int'(a[1:0]) * 8 +: 8] = wd[8 * i +: 8];
            ref_mem[a[7:2]] = w;
         end
      bad = -1;
      for (int i = 63; i >= 0; i--) if (mem[i] !== ref_mem[i]) bad = i;
      tests++;
      if (bad >= 0) begin
         fails++; $display("FAIL memory word=%0d got=%h want=%h", bad, mem[bad], ref_mem[bad]);
      end
      tests++;
      if (rd_total - rd0 != exp_rds || wr_total - wr0 != exp_wrs || viol != v0) begin
         fails++; $display("FAIL bus_activity reads=%0d writes=%0d viol=%0d want=%0d/%0d/0",
                           rd_total - rd0, wr_total - wr0, viol - v0, exp_rds, exp_wrs);
      end
   endtask

   task automatic test_reset;
      tests++;
      if ({req_ready, resp_valid, resp_err, mem_read, mem_write} !== 5'b10000) begin
         fails++; $display("FAIL reset_ctrl got=%b want=10000",
                           {req_ready, resp_valid, resp_err, mem_read, mem_write});
      end
      tests++;
      if (resp_rdata !== 32'd0 || mem_add !== 8'd0 || mem_wdata !== 32'd0) begin
         fails++; $display("FAIL reset_data got=%h/%h/%h want=0/0/0", resp_rdata, mem_add, mem_wdata);
      end
   endtask

   task automatic test_directed;
      logic [31:0] got;
      set_word(4, 32'hDEADBEEF);
      do_txn(1'b0, 3'd2, 8'h10, 32'd0, 0, got);
      tests++;
      if (got !== 32'hDEADBEEF) begin fails++; $display("FAIL lw got=%h want=deadbeef", got); end
      set_word(4, 32'h80112233);
      do_txn(1'b0, 3'd0, 8'h13, 32'd0, 1, got);
      tests++;
      if (got !== 32'hFFFFFF80) begin fails++; $display("FAIL lb got=%h want=ffffff80", got); end
      do_txn(1'b0, 3'd4, 8'h13, 32'd0, 0, got);
      tests++;
      if (got !== 32'h00000080) begin fails++; $display("FAIL lbu got=%h want=00000080", got); end
      set_word(8, 32'h11223344);
      do_txn(1'b1, 3'd0, 8'h21, 32'h000000AA, 0, got);
      tests++;
      if (mem[8] !== 32'h1122AA44) begin fails++; $display("FAIL sb got=%h want=1122aa44", mem[8]); end
      set_word(63, 32'hAABBCCDD);
      set_word(0, 32'h11223344);
      do_txn(1'b0, 3'd2, 8'hFE, 32'd0, 0, got);
      tests++;
      if (got !== 32'h3344AABB) begin fails++; $display("FAIL lw_wrap got=%h want=3344aabb", got); end
      set_word(0, 32'd0);
      set_word(1, 32'd0);
      do_txn(1'b1, 3'd1, 8'h03, 32'h0000BEEF, 0, got);
      tests++;
      if (mem[0] !== 32'hEF000000 || mem[1] !== 32'h000000BE) begin
         fails++; $display("FAIL sh_cross got=%h/%h want=ef000000/000000be", mem[0], mem[1]);
      end
      do_txn(1'b0, 3'd3, 8'h40, 32'd0, 4, got);
      do_txn(1'b1, 3'd5, 8'h44, 32'h12345678, 2, got);
   endtask

   task automatic test_random;
      logic [31:0] got;
      for (int t = 0; t < 200; t++)
         do_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
                $urandom, int'($urandom_range(0, 2)), got);
   endtask

   task automatic test_no_misalign;
      int rd0, wr0, lat;
      rd0 = n_rd_total; wr0 = n_wr_total;
      n_req_valid = 1'b1; n_req_we = 1'b1; n_req_funct3 = 3'd1; n_req_addr = 8'h03;
      n_req_wdata = 32'h0000BEEF;
      @(posedge clk); #1;
      n_req_valid = 1'b0;
      tests++;
      if (n_resp_valid !== 1'b1 || n_resp_err !== 1'b1 || n_resp_rdata !== 32'd0) begin
         fails++; $display("FAIL nm_sh_err got=%b/%b/%h want=1/1/0", n_resp_valid, n_resp_err, n_resp_rdata);
      end
      n_resp_ready = 1'b1; @(posedge clk); #1; n_resp_ready = 1'b0;
      tests++;
      if (n_rd_total != rd0 || n_wr_total != wr0) begin
         fails++; $display("FAIL nm_no_access reads=%0d writes=%0d want=0/0", n_rd_total - rd0, n_wr_total - wr0);
      end
      n_req_valid = 1'b1; n_req_we = 1'b0; n_req_funct3 = 3'd2; n_req_addr = 8'h20;
      @(posedge clk); #1;
      n_req_valid = 1'b0;
      lat = 1;
      while (!n_resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      tests++;
      if (lat != 2 || n_resp_err !== 1'b0 || n_resp_rdata !== ref_mem[8]) begin
         fails++; $display("FAIL nm_lw lat=%0d err=%b data=%h want=2/0/%h", lat, n_resp_err, n_resp_rdata, ref_mem[8]);
      end
      n_resp_ready = 1'b1; @(posedge clk); #1; n_resp_ready = 1'b0;
   endtask

   task automatic test_reset_mid_op;
      int bad;
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 8'h80; req_wdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      req_valid = 1'b0;
      tests++;
      if (mem_write !== 1'b1 || mem_add !== 8'h80) begin
         fails++; $display("FAIL wr0_entry got=%b/%h want=1/80", mem_write, mem_add);
      end
      rst = 1'b1;
      #1;
      tests++;
      if ({req_ready, resp_valid, resp_err, mem_read, mem_write} !== 5'b10000 ||
          resp_rdata !== 32'd0 || mem_add !== 8'd0 || mem_wdata !== 32'd0) begin
         fails++; $display("FAIL async_reset got=%b/%h/%h/%h want=10000/0/0/0",
                           {req_ready, resp_valid, resp_err, mem_read, mem_write}, resp_rdata, mem_add, mem_wdata);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      bad = -1;
      for (int i = 63; i >= 0; i--) if (mem[i] !== ref_mem[i]) bad = i;
      tests++;
      if (bad >= 0) begin fails++; $display("FAIL reset_no_write word=%0d got=%h want=%h", bad, mem[bad], ref_mem[bad]); end
   endtask

   initial begin
      rst = 1'b1; pl_en = 1'b0; pl_idx = '0; pl_val = '0;
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
      n_req_valid = 1'b0; n_req_we = 1'b0; n_req_funct3 = '0; n_req_addr = '0; n_req_wdata = '0;
      n_resp_ready = 1'b0;
      #1;
      test_reset();
      for (int i = 0; i < 64; i++) set_word(i, $urandom);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      test_directed();
      test_random();
      test_no_misalign();
      test_reset_mid_op();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
